mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between two requesters: m0 (CPU fetch/load-store sequencer, high priority) and m1 (auxiliary master such as debug or DMA).
- m0 has fixed priority, with a starvation limit that guarantees m1 service.
- Latches each granted request, drives the memory port until completion, and returns registered read data and fault status to the owner.
- Sits between the core sequencing logic and the memory module.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_select.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
//
// Purpose: FSM state encoding, fault bit positions, requester ids and the
//          latched request record used by mem_port_arbiter and mem_arb_select.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int FLT_OP      = 0;
  localparam int FLT_ADDR    = 1;
  localparam int FLT_ACCESS  = 2;
  localparam int FLT_TIMEOUT = 3;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef struct packed {
    logic        write;
    logic        mode;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - fixed-priority requester select with starvation guard
//
// Purpose: picks which requester wins when the arbiter is idle. m0 wins ties
//          until m1 has been passed over STARVE_LIMIT times in a row.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   m0_req, m1_req    pending requests
//   grant             the arbiter is accepting the current selection this cycle
//   sel_valid         at least one request is pending
//   sel_id            selected requester (REQ_M0 / REQ_M1)
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  input  logic grant,
  output logic sel_valid,
  output logic sel_id
);

  logic [3:0] starve_cnt;

  always_comb begin
    sel_valid = m0_req | m1_req;
    if (m0_req && m1_req) begin
      sel_id = (starve_cnt == 4'(STARVE_LIMIT)) ? REQ_M1 : REQ_M0;
    end else if (m1_req) begin
      sel_id = REQ_M1;
    end else begin
      sel_id = REQ_M0;
    end
  end

  // Counts m0 wins that left m1 waiting; any grant with m1 idle, or to m1,
  // means m1 is not being starved.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant) begin
      if (sel_id == REQ_M1 || !m1_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for the core's single memory port
//
// Purpose: grants m0 (high priority) or m1 the memory port, latches the
//          granted request, drives mem_* until the memory completes, and
//          returns registered read data and fault status to the owner.
// Optional: MEM_PORT_ARBITER_TIMEOUT_EN adds an ACTIVE-cycle watchdog that
//          ends a stuck access with fault 4'b1000 and rdata 0.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mX_req/write/mode/size/addr/wdata  requester X access fields
//   mX_gnt                          1-cycle pulse, fields latched
//   mX_done                         1-cycle pulse, mX_rdata/mX_fault valid
//   mX_rdata, mX_fault              held until that port's next done
//   mem_enable/write/mode/size/addr/wdata  memory port command
//   mem_rdata, mem_busy, mem_*_fault       memory port response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic        m0_mode,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic        m1_mode,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [3:0]  m0_fault,
  output logic [3:0]  m1_fault,
  output logic        mem_enable,
  output logic        mem_write,
  output logic        mem_mode,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        mem_op_fault,
  input  logic        mem_addr_fault,
  input  logic        mem_access_fault
);

  logic [1:0] state;
  logic       owner;
  mem_req_t   lat;
  mem_req_t   req_sel;
  logic       sel_valid;
  logic       sel_id;
  logic       grant;
  logic       active;
  logic [3:0] fault_now;
  logic       complete;
  logic       timed_out;

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .grant    (grant),
    .sel_valid(sel_valid),
    .sel_id   (sel_id)
  );

  // Grant is suppressed while reset is held so no pulse is seen for a
  // request the FSM will not latch.
  assign grant  = (state == IDLE) && sel_valid && !reset;
  assign m0_gnt = grant && (sel_id == REQ_M0);
  assign m1_gnt = grant && (sel_id == REQ_M1);

  always_comb begin
    if (sel_id == REQ_M1) begin
      req_sel = '{write: m1_write, mode: m1_mode, size: m1_size, addr: m1_addr, wdata: m1_wdata};
    end else begin
      req_sel = '{write: m0_write, mode: m0_mode, size: m0_size, addr: m0_addr, wdata: m0_wdata};
    end
  end

  // Memory command is only presented while ACTIVE; otherwise the port is quiet.
  assign active     = (state == ACTIVE);
  assign mem_enable = active;
  assign mem_write  = active & lat.write;
  assign mem_mode   = active & lat.mode;
  assign mem_size   = active ? lat.size  : 2'd0;
  assign mem_addr   = active ? lat.addr  : 32'd0;
  assign mem_wdata  = active ? lat.wdata : 32'd0;

  assign m0_done = (state == RESP) && (owner == REQ_M0);
  assign m1_done = (state == RESP) && (owner == REQ_M1);

  always_comb begin
    fault_now              = 4'd0;
    fault_now[FLT_OP]      = mem_op_fault;
    fault_now[FLT_ADDR]    = mem_addr_fault;
    fault_now[FLT_ACCESS]  = mem_access_fault;
  end

  // Any fault ends the access even if the memory still reports busy.
  assign complete = !mem_busy || (|fault_now);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic [6:0] wd_cnt;

  // wd_cnt holds (ACTIVE cycles so far - 1), so the limit fires on the
  // TIMEOUT_CYCLES-th ACTIVE cycle; a real completion in that cycle wins.
  assign timed_out = active && !complete && (wd_cnt == 7'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= 7'd0;
    end else if (grant) begin
      wd_cnt <= 7'd0;
    end else if (active) begin
      wd_cnt <= wd_cnt + 7'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= REQ_M0;
      lat      <= '0;
      m0_rdata <= 32'd0;
      m1_rdata <= 32'd0;
      m0_fault <= 4'd0;
      m1_fault <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= sel_id;
            lat   <= req_sel;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (complete || timed_out) begin
            if (owner == REQ_M1) begin
              m1_rdata <= timed_out ? 32'd0 : mem_rdata;
              m1_fault <= timed_out ? 4'b1000 : fault_now;
            end else begin
              m0_rdata <= timed_out ? 32'd0 : mem_rdata;
              m0_fault <= timed_out ? 4'b1000 : fault_now;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m0_mode, m1_req, m1_write, m1_mode;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  m0_fault, m1_fault;
  logic        mem_enable, mem_write, mem_mode;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_busy, mem_op_fault, mem_addr_fault, mem_access_fault;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  int          gnt_seen = 0;
  int          act_cnt = 0;
  int          busy_n = 0;
  logic [31:0] rd_val = 32'd0;
  logic [2:0]  flt_vec = 3'd0;

  logic        exp_gnt[$];
  logic [67:0] exp_mem[$];
  logic [36:0] exp_resp[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_mode(m0_mode), .m0_size(m0_size),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_mode(m1_mode), .m1_size(m1_size),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_fault(m0_fault), .m1_fault(m1_fault),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_mode(mem_mode),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_op_fault(mem_op_fault),
    .mem_addr_fault(mem_addr_fault), .mem_access_fault(mem_access_fault)
  );

  // Memory model: busy for the first busy_n enabled cycles, faults on the first.
  always @(posedge clk) act_cnt <= mem_enable ? act_cnt + 1 : 0;
  assign mem_busy         = mem_enable && (act_cnt < busy_n);
  assign mem_rdata        = rd_val;
  assign mem_op_fault     = mem_enable && (act_cnt == 0) && flt_vec[0];
  assign mem_addr_fault   = mem_enable && (act_cnt == 0) && flt_vec[1];
  assign mem_access_fault = mem_enable && (act_cnt == 0) && flt_vec[2];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_txn(input logic port, input logic [31:0] rdata, input logic [3:0] fault,
                          input logic with_resp);
    exp_gnt.push_back(port);
    if (port)
      exp_mem.push_back({m1_write, m1_mode, m1_size, m1_addr, m1_wdata});
    else
      exp_mem.push_back({m0_write, m0_mode, m0_size, m0_addr, m0_wdata});
    if (with_resp) exp_resp.push_back({port, rdata, fault});
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_resp.size() != 0; i++) smp();
    chk("resp_drain", 72'(exp_resp.size()), 72'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant, a
  // response, or the first cycle of a memory command.
  always @(negedge clk) begin
    if (m0_gnt || m1_gnt) begin
      gnt_seen++;
      if (exp_gnt.size() == 0) chk("gnt_unexpected", {m0_gnt, m1_gnt}, 72'd0);
      else chk("gnt_order", {m0_gnt, m1_gnt}, exp_gnt[0] ? 72'b01 : 72'b10);
      if (exp_gnt.size() != 0) void'(exp_gnt.pop_front());
    end
    if (m0_done || m1_done) begin
      done_seen++;
      if (exp_resp.size() == 0) chk("done_unexpected", {m0_done, m1_done}, 72'd0);
      else chk("resp", {m1_done, m1_done ? m1_rdata : m0_rdata, m1_done ? m1_fault : m0_fault},
               exp_resp.pop_front());
    end
    if (mem_enable && act_cnt == 0) begin
      if (exp_mem.size() == 0) chk("mem_unexpected", mem_enable, 72'd0);
      else chk("mem_cmd", {mem_write, mem_mode, mem_size, mem_addr, mem_wdata}, exp_mem.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int start;
    int dseen;
    logic g[6];
    reset = 1'b1;
    {m0_req, m0_write, m0_mode, m1_req, m1_write, m1_mode} = '0;
    {m0_size, m1_size} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    smp();
    chk("rst_pulses", {m0_gnt, m1_gnt, m0_done, m1_done}, 72'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 72'd0);
    chk("rst_fault", {m0_fault, m1_fault}, 72'd0);
    chk("rst_mem", {mem_enable, mem_write, mem_mode, mem_size, mem_addr, mem_wdata}, 72'd0);

    // m0 read, busy 2 ACTIVE cycles
    cyc();
    m0_req = 1; m0_write = 0; m0_size = 2'd2; m0_addr = 32'h100; m0_wdata = 32'd0;
    busy_n = 2; rd_val = 32'hDEADBEEF;
    push_txn(1'b0, 32'hDEADBEEF, 4'd0, 1'b1);
    smp(); chk("t1_gnt_c0", m0_gnt, 72'd1);
    cyc(); m0_req = 0; m0_addr = 32'hFFFF_FFFF;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) cyc();
      smp(); chk($sformatf("t1_en_c%0d", c), {mem_enable, mem_addr}, {1'b1, 32'h100});
    end
    cyc(); smp();
    chk("t1_c4", {mem_enable, m0_done, m0_rdata, m0_fault}, {1'b0, 1'b1, 32'hDEADBEEF, 4'd0});

    // Starvation: both held, grant order m0 x4, m1, m0
    cyc();
    busy_n = 0; rd_val = 32'hA5A5_0000;
    m0_req = 1; m0_addr = 32'h200; m0_size = 2'd2;
    m1_req = 1; m1_write = 1; m1_mode = 1; m1_size = 2'd1; m1_addr = 32'h300; m1_wdata = 32'h1234_5678;
    g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    foreach (g[i]) push_txn(g[i], 32'hA5A5_0000, 4'd0, 1'b1);
    start = gnt_seen;
    for (int i = 0; i < 60 && (gnt_seen - start) < 6; i++) begin
      smp(); #1;
    end
    chk("t2_grants", 72'(gnt_seen - start), 72'd6);
    cyc(); m0_req = 0; m1_req = 0;
    drain(20);

    // Address fault on 1st ACTIVE cycle while busy, m1 write
    cyc();
    m1_req = 1; m1_write = 1; m1_mode = 0; m1_size = 2'd2; m1_addr = 32'h0FFC; m1_wdata = 32'hCAFEF00D;
    busy_n = 5; flt_vec = 3'b010; rd_val = 32'h0BAD_0BAD;
    push_txn(1'b1, 32'h0BAD_0BAD, 4'b0010, 1'b1);
    smp(); chk("t3_gnt", m1_gnt, 72'd1);
    cyc(); m1_req = 0;
    smp(); chk("t3_en", mem_enable, 72'd1);
    cyc(); smp();
    chk("t3_done", {mem_enable, m1_done, m1_fault}, {1'b0, 1'b1, 4'b0010});
    cyc(); flt_vec = 3'b000;

    // m1 arrives during m0 ACTIVE and waits for IDLE
    cyc();
    m0_req = 1; m0_write = 0; m0_addr = 32'h400; busy_n = 3; rd_val = 32'h1111_2222;
    push_txn(1'b0, 32'h1111_2222, 4'd0, 1'b1);
    cyc(); m0_req = 0;
    cyc();
    m1_req = 1; m1_write = 0; m1_mode = 1; m1_size = 2'd0; m1_addr = 32'h500; m1_wdata = 32'h55;
    push_txn(1'b1, 32'h1111_2222, 4'd0, 1'b1);
    for (int c = 2; c <= 5; c++) begin
      if (c > 2) cyc();
      smp(); chk($sformatf("t4_nognt_c%0d", c), m1_gnt, 72'd0);
    end
    chk("t4_m0_done_c5", m0_done, 72'd1);
    cyc(); smp(); chk("t4_m1_gnt_c6", m1_gnt, 72'd1);
    cyc(); m1_req = 0; m1_addr = 32'hDEAD_0000; m1_mode = 0;
    drain(20);

    // Reset in the 2nd ACTIVE cycle aborts without done
    cyc();
    m0_req = 1; m0_addr = 32'h600; busy_n = 10; rd_val = 32'h3333;
    push_txn(1'b0, 32'd0, 4'd0, 1'b0);
    cyc(); m0_req = 0;
    smp(); chk("t5_en_c1", mem_enable, 72'd1);
    cyc(); reset = 1;
    smp(); chk("t5_en_c2", mem_enable, 72'd1);
    dseen = done_seen;
    cyc(); reset = 0;
    smp();
    chk("t5_abort", {mem_enable, m0_done, m0_rdata, m0_fault}, 72'd0);
    repeat (10) smp();
    chk("t5_no_done", 72'(done_seen - dseen), 72'd0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Watchdog: busy stuck, done after 8 ACTIVE cycles
    cyc();
    m0_req = 1; m0_addr = 32'h700; busy_n = 1000; rd_val = 32'h7777;
    push_txn(1'b0, 32'd0, 4'b1000, 1'b1);
    cyc(); m0_req = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) cyc();
      smp(); chk($sformatf("t6_en_c%0d", c), mem_enable, 72'd1);
    end
    cyc(); smp();
    chk("t6_timeout", {mem_enable, m0_done, m0_rdata, m0_fault}, {1'b0, 1'b1, 32'd0, 4'b1000});
    busy_n = 0;
`endif

    repeat (4) smp();
    chk("end_gnt_q", 72'(exp_gnt.size()), 72'd0);
    chk("end_mem_q", 72'(exp_mem.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
